// File: rtl/pwm_capture.sv
// PWM pulse-width/period capture with stuck-input timeout.
// Measures high time and rise-to-rise period of an asynchronous PWM input.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PWM_IN,
  output logic [CNT_W-1:0] HIGH_CNT,
  output logic [CNT_W-1:0] PERIOD_CNT,
  output logic [7:0]       DUTY_CYCLE,
  output logic             VALID,
  output logic             TIMEOUT
);

  localparam int EW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [EW-1:0]    EDGE_LAST = EW'(TIMEOUT_CYC - 1);
  localparam logic [EW-1:0]    EDGE_TOP  = EW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    if (x == CNT_MAX) return x;
    else              return x + CNT_ONE;
  endfunction

  function automatic logic [7:0] duty_of(input logic [CNT_W-1:0] x);
    if (x > CNT_W'(255)) return 8'hFF;
    else                 return x[7:0];
  endfunction

  logic [1:0]       rst_sync_q;
  logic             run;
  logic [1:0]       sync_q;
  logic             dly_q;
  logic             rise_q, fall_q;
  logic             rise_d, fall_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [EW-1:0]    edge_q, edge_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [7:0]       duty_q, duty_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             tmo_fire;

  // Reset release is retimed so counting starts on a clean clock boundary.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run = rst_sync_q[1];

  assign rise_d = sync_q[1] & ~dly_q;
  assign fall_d = ~sync_q[1] & dly_q;

  // A strobe in the same cycle always wins over the timeout.
  assign tmo_fire = !rise_q && !fall_q && !timeout_q && (edge_q == EDGE_LAST);

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    per_d        = per_q;
    shadow_d     = shadow_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    duty_d       = duty_q;
    valid_d      = 1'b0;
    timeout_d    = timeout_q;

    if (rise_q || fall_q)   edge_d = '0;
    else if (edge_q == EDGE_TOP) edge_d = edge_q;
    else                    edge_d = edge_q + EW'(1);

    if (rise_q) timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rise_q) begin
          hi_d    = CNT_ONE;
          per_d   = CNT_ONE;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        hi_d  = sat_inc(hi_q);
        per_d = sat_inc(per_q);
        if (fall_q) begin
          shadow_d = hi_q;
          state_d  = S_LOW;
        end
      end
      S_LOW: begin
        per_d = sat_inc(per_q);
        if (rise_q) begin
          high_cnt_d   = shadow_q;
          period_cnt_d = per_q;
          duty_d       = duty_of(shadow_q);
          valid_d      = 1'b1;
          hi_d         = CNT_ONE;
          per_d        = CNT_ONE;
          state_d      = S_HIGH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tmo_fire) begin
      state_d   = S_IDLE;
      timeout_d = 1'b1;
      valid_d   = 1'b1;
      duty_d    = sync_q[1] ? 8'hFF : 8'h00;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q       <= 2'b00;
      dly_q        <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      state_q      <= S_IDLE;
      hi_q         <= '0;
      per_q        <= '0;
      shadow_q     <= '0;
      edge_q       <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      duty_q       <= 8'h00;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else if (run) begin
      sync_q       <= {sync_q[0], PWM_IN};
      dly_q        <= sync_q[1];
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      state_q      <= state_d;
      hi_q         <= hi_d;
      per_q        <= per_d;
      shadow_q     <= shadow_d;
      edge_q       <= edge_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      duty_q       <= duty_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign HIGH_CNT   = high_cnt_q;
  assign PERIOD_CNT = period_cnt_q;
  assign DUTY_CYCLE = duty_q;
  assign VALID      = valid_q;
  assign TIMEOUT    = timeout_q;

endmodule
